// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD scan controller: conversion FSM
// states, digit count, 7-segment codes and one double-dabble step.
package bcd_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } bcd_state_t;

  // Active-high segment codes, bit 0 = A ... bit 6 = G.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // One double-dabble iteration on the {bcd[11:0], bin[7:0]} register:
  // correct every BCD nibble >= 5 by +3, then shift the whole word left.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[8 + 4*i +: 4] >= 4'd5) begin
        adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
      end
    end
    return {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_scan_controller_if.sv
// Bus between the value source / display pins and the BCD scan controller.
// Handshake: load and scan_tick are single-cycle strobes sampled on the
// rising clock edge; there is no ready signal -- a load is always accepted
// (captured directly when idle, otherwise held as the latest pending value),
// and busy reports that a conversion is in flight.
interface bcd_scan_if;
  import bcd_pkg::*;

  logic [7:0]  value;
  logic        load;
  logic        busy;
  logic        scan_tick;
  logic [11:0] digits;
  logic [6:0]  segments;
  logic [2:0]  enable;
  bcd_state_t  fsm_state;

  modport master (
    output value, load, scan_tick,
    input  busy, digits, segments, enable, fsm_state
  );

  modport slave (
    input  value, load, scan_tick,
    output busy, digits, segments, enable, fsm_state
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment lookup; non-decimal codes show a dash.
module seg7_decode
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one digit.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_controller.sv
// Binary-to-BCD conversion (sequential double dabble) with an atomic commit
// to a display register, plus a 3-digit multiplexed 7-segment scanner with
// inter-digit blanking and optional leading-zero suppression.
module bcd_scan_controller
  import bcd_pkg::*;
#(
  parameter int BLANK_CYCLES = 2,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic     hwclk,
  input  logic     resetn,
  bcd_scan_if.slave bus
);

  localparam int CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  // Conversion state
  bcd_state_t  state, state_nx;
  logic [19:0] sr, sr_nx;
  logic [2:0]  step, step_nx;
  logic        pend, pend_nx;
  logic [7:0]  pend_val, pend_val_nx;
  logic [11:0] digits_q, digits_nx;

  // Scan state
  logic [1:0]    idx;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] bcnt_dec;
  logic          started;
  logic [2:0]    en_q;
  logic [6:0]    seg_q;
  logic [3:0]    sel_digit;
  logic [6:0]    dec_seg;
  logic          suppress;

  // Conversion FSM registers and the datapath they own.
  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      sr       <= '0;
      step     <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      digits_q <= '0;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      step     <= step_nx;
      pend     <= pend_nx;
      pend_val <= pend_val_nx;
      digits_q <= digits_nx;
    end
  end

  // Next-state logic: capture, eight dabble shifts, commit; loads seen while
  // busy overwrite a single pending slot (last one wins). A load arriving in
  // the commit cycle is newer than any pending value, so it is captured.
  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    step_nx     = step;
    pend_nx     = pend;
    pend_val_nx = pend_val;
    digits_nx   = digits_q;
    case (state)
      IDLE: begin
        if (bus.load) begin
          sr_nx    = {12'd0, bus.value};
          step_nx  = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        sr_nx   = dabble_step(sr);
        step_nx = step + 3'd1;
        if (step == 3'd7) begin
          state_nx = COMMIT;
        end
        if (bus.load) begin
          pend_nx     = 1'b1;
          pend_val_nx = bus.value;
        end
      end
      COMMIT: begin
        digits_nx = sr[19:8];
        if (bus.load) begin
          sr_nx    = {12'd0, bus.value};
          step_nx  = '0;
          pend_nx  = 1'b0;
          state_nx = SHIFT;
        end else if (pend) begin
          sr_nx    = {12'd0, pend_val};
          step_nx  = '0;
          pend_nx  = 1'b0;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Select the digit for the current scan slot and decide whether it is a
  // leading zero that should stay dark.
  always_comb begin
    case (idx)
      2'd0:    sel_digit = digits_q[3:0];
      2'd1:    sel_digit = digits_q[7:4];
      default: sel_digit = digits_q[11:8];
    endcase
    suppress = LZ_BLANK &&
               (((idx == 2'd2) && (digits_q[11:8] == 4'd0)) ||
                ((idx == 2'd1) && (digits_q[11:4] == 8'd0)));
    bcnt_dec = (bcnt != '0) ? bcnt - CW'(1) : '0;
  end

  seg7_decode u_dec (
    .bcd (sel_digit),
    .seg (dec_seg)
  );

  // Scanner: a tick advances the slot and blanks; the slot lights on the
  // edge where the blank counter runs out (so BLANK_CYCLES dark clocks,
  // minimum one because the tick itself turns the enables off).
  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      idx     <= '0;
      bcnt    <= '0;
      started <= 1'b0;
      en_q    <= '0;
      seg_q   <= '0;
    end else if (bus.scan_tick) begin
      started <= 1'b1;
      idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      bcnt    <= CW'(BLANK_CYCLES);
      en_q    <= '0;
      seg_q   <= '0;
    end else begin
      bcnt <= bcnt_dec;
      if (started && (bcnt_dec == '0) && !suppress) begin
        en_q  <= 3'b001 << idx;
        seg_q <= dec_seg;
      end else begin
        en_q  <= '0;
        seg_q <= '0;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.digits    = digits_q;
  assign bus.enable    = en_q;
  assign bus.segments  = seg_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Bench for bcd_scan_controller: two instances (default parameters, and
// BLANK_CYCLES=4 / LZ_BLANK=0) share one stimulus stream and are compared
// every clock against an arithmetic reference model.
module tb_bcd_scan_controller;
  import bcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic hwclk  = 1'b0;
  logic resetn = 1'b0;
  always #5 hwclk = ~hwclk;

  bcd_scan_if bus0();
  bcd_scan_if bus1();

  bcd_scan_controller u0 (
    .hwclk  (hwclk),
    .resetn (resetn),
    .bus    (bus0)
  );

  bcd_scan_controller #(.BLANK_CYCLES(4), .LZ_BLANK(1'b0)) u1 (
    .hwclk  (hwclk),
    .resetn (resetn),
    .bus    (bus1)
  );

  // ---------------- reference model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  int          m_left;          // edges until the commit edge; 0 = idle
  bit          m_pend;
  logic [7:0]  m_pend_val;
  logic [11:0] m_digits;
  logic [11:0] exp_q[$];        // expected BCD of the conversion in flight

  bit          m_started[2];
  int          m_slot[2];
  int          m_blank[2];
  logic [2:0]  m_en[2];
  logic [6:0]  m_seg[2];
  int          p_blank[2] = '{2, 4};
  bit          p_lz[2]    = '{1'b1, 1'b0};

  logic [6:0]  seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [7:0]  special[8]  = '{8'd0, 8'd5, 8'd7, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_left     = 0;
    m_pend     = 1'b0;
    m_pend_val = '0;
    m_digits   = '0;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 1'b0;
      m_slot[k]    = 0;
      m_blank[k]   = 0;
      m_en[k]      = '0;
      m_seg[k]     = '0;
    end
  endtask

  // Advance the model by one rising edge with the inputs held for that edge.
  task automatic model_edge(input bit ld, input logic [7:0] val, input bit tk);
    logic [11:0] old_d;
    logic [3:0]  digit;
    bit          hidden;
    old_d = m_digits;
    for (int k = 0; k < 2; k++) begin
      if (tk) begin
        m_started[k] = 1'b1;
        m_slot[k]    = (m_slot[k] + 1) % 3;
        m_blank[k]   = p_blank[k];
        m_en[k]      = '0;
        m_seg[k]     = '0;
      end else begin
        if (m_blank[k] > 0) m_blank[k]--;
        m_en[k]  = '0;
        m_seg[k] = '0;
        if (m_started[k] && m_blank[k] == 0) begin
          digit  = old_d[4*m_slot[k] +: 4];
          hidden = p_lz[k] && ((m_slot[k] == 2 && old_d[11:8] == 4'd0) ||
                               (m_slot[k] == 1 && old_d[11:4] == 8'd0));
          if (!hidden) begin
            m_en[k]  = 3'(1 << m_slot[k]);
            m_seg[k] = seg_tab[digit];
          end
        end
      end
    end
    if (m_left == 0) begin
      if (ld) begin
        exp_q.push_back(to_bcd(int'(val)));
        m_left = 9;
      end
    end else if (m_left == 1) begin
      if (exp_q.size() == 0) begin
        check("model_queue", 32'd0, 32'd1);
      end else begin
        m_digits = exp_q.pop_front();
      end
      if (ld) begin
        exp_q.push_back(to_bcd(int'(val)));
        m_left = 9;
        m_pend = 1'b0;
      end else if (m_pend) begin
        exp_q.push_back(to_bcd(int'(m_pend_val)));
        m_left = 9;
        m_pend = 1'b0;
      end else begin
        m_left = 0;
      end
    end else begin
      m_left--;
      if (ld) begin
        m_pend     = 1'b1;
        m_pend_val = val;
      end
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare_all();
    check("busy",       32'(bus0.busy),                 32'(m_left != 0));
    check("busy_b",     32'(bus1.busy),                 32'(m_left != 0));
    check("idle_state", 32'(bus0.fsm_state == IDLE),    32'(m_left == 0));
    check("digits",     32'(bus0.digits),               32'(m_digits));
    check("digits_b",   32'(bus1.digits),               32'(m_digits));
    check("enable",     32'(bus0.enable),               32'(m_en[0]));
    check("segments",   32'(bus0.segments),             32'(m_seg[0]));
    check("enable_b",   32'(bus1.enable),               32'(m_en[1]));
    check("segments_b", 32'(bus1.segments),             32'(m_seg[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ld, input logic [7:0] val, input bit tk);
    bus0.load      = ld;
    bus1.load      = ld;
    bus0.value     = val;
    bus1.value     = val;
    bus0.scan_tick = tk;
    bus1.scan_tick = tk;
  endtask

  // Called just after a falling edge; one full clock, then compare.
  task automatic step(input bit ld, input logic [7:0] val, input bit tk);
    drive(ld, val, tk);
    @(posedge hwclk);
    cyc++;
    model_edge(ld, val, tk);
    @(negedge hwclk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'd0, 1'b1);
      idle(gap);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    drive(1'b0, 8'd0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge hwclk);
    compare_all();
    resetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit         ld, tk;
    logic [7:0] v;
    drive(1'b0, 8'd0, 1'b0);
    model_reset();
    repeat (2) @(negedge hwclk);
    compare_all();
    resetn = 1'b1;

    // Largest value, busy for nine clocks.
    step(1'b1, 8'd255, 1'b0);
    idle(9);
    ticks(4, 6);

    // Single-digit value with leading-zero suppression.
    step(1'b1, 8'd7, 1'b0);
    idle(9);
    ticks(6, 6);

    // Overlapping loads: 42 is superseded by 43 before it can start.
    step(1'b1, 8'd100, 1'b0);
    idle(2);
    step(1'b1, 8'd42, 1'b0);
    idle(1);
    step(1'b1, 8'd43, 1'b0);
    idle(14);
    ticks(4, 6);

    // Second tick during blanking skips a slot.
    step(1'b1, 8'd123, 1'b0);
    idle(9);
    step(1'b0, 8'd0, 1'b1);
    idle(1);
    step(1'b0, 8'd0, 1'b1);
    idle(8);

    // Zero shown on the ones slot; tens/hundreds depend on LZ_BLANK.
    step(1'b1, 8'd5, 1'b0);
    idle(9);
    ticks(6, 5);

    // Load landing in the commit cycle, no bubble.
    step(1'b1, 8'd61, 1'b0);
    idle(8);
    step(1'b1, 8'd9, 1'b0);
    idle(10);

    // Reset mid-conversion discards everything.
    step(1'b1, 8'd200, 1'b0);
    idle(3);
    async_reset();
    ticks(4, 5);
    idle(12);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      ld = ($urandom_range(0, 11) == 0);
      tk = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) v = special[$urandom_range(0, 7)];
      else                           v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) async_reset();
      else                             step(ld, v, tk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_scan_controller.md
# bcd_scan_controller

Sequencing controller that turns an 8-bit binary value into three BCD digits and time-multiplexes them onto a 3-digit common-enable 7-segment display. It sits between the value source (for example a free-running counter) and the display pins. It runs a sequential double-dabble conversion on request, commits the result atomically to a display register, and scans digits on a divided strobe from a `scaler`, with inter-digit blanking and optional leading-zero suppression.

## Interface
- `BLANK_CYCLES`, default 2: clocks with all enables off after each digit advance (anti-ghosting); 0 is legal.
- `LZ_BLANK`, default 1: 1 suppresses leading zeros; 0 shows all three digits.
- `hwclk  in  1`: single clock; all state on the rising edge.
- `resetn  in  1`: reset, asynchronous and active-low.
- `value  in  8`: binary value to display; sampled only when a load is accepted.
- `load  in  1`: one-cycle conversion request.
- `busy  out  1`: high while a conversion is in flight.
- `scan_tick  in  1`: one-cycle digit-advance strobe, synchronous to `hwclk`.
- `digits  out  12`: committed BCD value; [3:0] ones, [7:4] tens, [11:8] hundreds.
- `segments  out  7`: active-high; bit 0 = A, bit 6 = G.
- `enable  out  3`: active-high one-hot; bit 0 = ones digit.

## Operation
- Reset values: `busy`, `segments`, `enable` and `digits` are 0; digit index is 0; FSM is IDLE; the pending flag is clear.
- Conversion FSM states:
  - IDLE: if `load` is high, capture `value` into the shift register, clear the BCD accumulator, clear the step counter, go to SHIFT.
  - SHIFT: each cycle, add 3 to any BCD nibble ≥ 5, then shift the {BCD, binary} register left by 1. After the 8th shift, go to COMMIT.
  - COMMIT: write the accumulator to `digits`. If a load is pending, capture it and go to SHIFT; otherwise go to IDLE.
- `load` while busy (SHIFT/COMMIT): latch `value` into a pending register and set the pending flag. Last load wins; loads are never dropped entirely.
- Accumulator is 12 bits. Hundreds never exceeds 2 (255 → 2,5,5).
- Scan datapath:
  - On `scan_tick`, index advances 0→1→2→0, `enable` goes to 0, and the blank counter loads `BLANK_CYCLES`.
  - When the counter reaches 0, drive the selected digit.
  - `scan_tick` during blanking advances the index again and reloads the counter.
  - Before the first tick after reset, `enable` stays 0.
- Leading-zero suppression (`LZ_BLANK` = 1):
  - Hundreds is suppressed when it is 0.
  - Tens is suppressed when hundreds and tens are both 0.
  - Ones is never suppressed.
  - A suppressed slot drives `enable` = 0 and `segments` = 0 for its whole period.
- Segment codes: 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F. Codes 10–15 give 0x40 (dash).
- `segments` is 0 whenever `enable` is 0.

## Timing
- Load accepted at edge E0:
  - `busy` is high after E0.
  - Shifts occur at E1–E8.
  - `digits` updates and `busy` drops at E9 (latency 9 clocks), unless a load is pending; in that case `busy` stays high and the next conversion starts at E10.
- `load` and COMMIT in the same cycle: the load becomes pending-then-captured, with no bubble.
- `segments` and `enable` are registered; they change 1 clock after the cause (tick, blank expiry, or commit).
- After a `digits` update, the active slot shows the new value 1 clock later. The scan phase is not reset.
- `resetn` low at any time, including mid-SHIFT:
  - All outputs go to reset values immediately.
  - The in-flight conversion and pending load are discarded.
  - No commit occurs.

## Structure
- Package `bcd_pkg`:
  - FSM state enum (IDLE, SHIFT, COMMIT).
  - `NUM_DIGITS` = 3.
  - Segment constant table for 0–9 and the dash.
- Sub-module `seg7_decode`: combinational 4-bit BCD → 7-segment lookup using `bcd_pkg` constants. It is instantiated once on the selected digit.

## Test plan
- Reset, then load 255 → `busy` high 9 clocks; `digits` = 0x255; `busy` low at E9.
- `LZ_BLANK` = 1, load 7, 3 scan ticks → slot 0: `enable` = 001, `segments` = 0x07; slots 1 and 2: `enable` = 000, `segments` = 0x00.
- Load 100, then load 42 at E3 and load 43 at E5 → `digits` = 0x100 at E9, then 0x043 at E18; 42 is never shown.
- `BLANK_CYCLES` = 4, `digits` = 0x123, tick → `enable` = 000 for 4 clocks, then 010 with `segments` = 0x5B. A second tick during blanking skips to slot 2 (`segments` = 0x06).
- `LZ_BLANK` = 0, load 5 → slots show 0x6D, 0x3F, 0x3F on `enable` 001, 010, 100 in turn.
- Load 200, assert `resetn` low at E4 → all outputs 0 immediately. After release, `digits` stays 0 until a new load.
